computer_move_generator: RTL and testbench

Automatic opponent for the tic-tac-toe game top. On request it snapshots the nine board cells. It then searches, one line or cell per cycle, for a winning move, then a blocking move, then a fixed preference order. It drives computer_position plus a one-cycle pc strobe into the game's computer-move inputs. It is the producer side of the interface the game consumes.

---
 rtl/ttt_pkg.sv | 57 +++++
 rtl/ttt_line_eval.sv | 33 +++
 rtl/computer_move_generator.sv | 147 ++++++++++++++
 tb/tb_computer_move_generator.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe computer opponent: cell codes,
// position codes, the winning-line table, the static preference list and
// the search state encoding.
package ttt_pkg;

   localparam logic [1:0] EMPTY  = 2'b00;
   localparam logic [1:0] PLAYER = 2'b01;
   localparam logic [1:0] COMP   = 2'b10;

   localparam logic [3:0] POS_NONE = 4'd15;

   // Eight lines, three zero-based cell indices each (cell 1 -> 0).
   localparam logic [0:7][0:2][3:0] LINE_TBL = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

   // Static fallback order: centre, corners, then edges.
   localparam logic [0:8][3:0] PREF_TBL = '{
      4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
   };

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WIN    = 3'd1,
      S_BLOCK  = 3'd2,
      S_STATIC = 3'd3,
      S_ISSUE  = 3'd4,
      S_NONE   = 3'd5
   } state_t;

   // Cell index of one slot of a line; out-of-range slots map to cell 0.
   function automatic logic [3:0] line_cell(input logic [2:0] line, input logic [1:0] slot);
      case (slot)
         2'd0:    return LINE_TBL[line][0];
         2'd1:    return LINE_TBL[line][1];
         2'd2:    return LINE_TBL[line][2];
         default: return 4'd0;
      endcase
   endfunction

   // Cell index of one preference entry; out-of-range entries map to cell 0.
   function automatic logic [3:0] pref_cell(input logic [3:0] idx);
      if (idx < 4'd9) begin
         return PREF_TBL[idx];
      end else begin
         return 4'd0;
      end
   endfunction

endpackage

// File: rtl/ttt_line_eval.sv
// Combinational evaluation of one board line: a hit means exactly two cells
// carry the given mark and the third is empty; o_slot names the empty one.
module ttt_line_eval
   import ttt_pkg::*;
(
   input  logic [1:0] i_cell0,
   input  logic [1:0] i_cell1,
   input  logic [1:0] i_cell2,
   input  logic [1:0] i_mark,
   output logic       o_hit,
   output logic [1:0] o_slot
);

   logic [1:0] w_mark_cnt;
   logic [1:0] w_empty_cnt;

   // Count marked and empty cells, then locate the first empty slot.
   always_comb begin
      w_mark_cnt  = {1'b0, (i_cell0 == i_mark)} + {1'b0, (i_cell1 == i_mark)}
                  + {1'b0, (i_cell2 == i_mark)};
      w_empty_cnt = {1'b0, (i_cell0 == EMPTY)} + {1'b0, (i_cell1 == EMPTY)}
                  + {1'b0, (i_cell2 == EMPTY)};
      o_hit       = (w_mark_cnt == 2'd2) && (w_empty_cnt == 2'd1);
      if (i_cell0 == EMPTY) begin
         o_slot = 2'd0;
      end else if (i_cell1 == EMPTY) begin
         o_slot = 2'd1;
      end else begin
         o_slot = 2'd2;
      end
   end

endmodule

// File: rtl/computer_move_generator.sv
// Computer opponent: snapshots the board on request, searches for a win,
// then a block, then the static preference list, one step per cycle, and
// strobes the chosen cell (pc) or reports that no move exists (no_move).
module computer_move_generator
   import ttt_pkg::*;
#(
   parameter logic BLOCK_EN = 1'b1,
   parameter int   POS_W    = 4
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             move_req,
   input  logic [1:0]       pos1,
   input  logic [1:0]       pos2,
   input  logic [1:0]       pos3,
   input  logic [1:0]       pos4,
   input  logic [1:0]       pos5,
   input  logic [1:0]       pos6,
   input  logic [1:0]       pos7,
   input  logic [1:0]       pos8,
   input  logic [1:0]       pos9,
   input  logic [1:0]       who,
   output logic [POS_W-1:0] computer_position,
   output logic             pc,
   output logic             busy,
   output logic             no_move
);

   state_t           r_state;
   state_t           w_next_state;
   logic [3:0]       r_idx;
   logic [3:0]       w_next_idx;
   logic [1:0]       r_cells [9];
   logic [1:0]       w_board [9];
   logic [POS_W-1:0] r_pos;
   logic             r_pc;
   logic             r_busy;
   logic             r_no_move;
   logic [3:0]       w_choice;
   logic [1:0]       w_mark;
   logic             w_hit;
   logic [1:0]       w_slot;
   logic [3:0]       w_pref;

   assign w_board = '{pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9};
   assign w_pref  = pref_cell(r_idx);

   // One shared line evaluator; the mark selects win (own) or block (player).
   ttt_line_eval u_line_eval (
      .i_cell0 (r_cells[line_cell(r_idx[2:0], 2'd0)]),
      .i_cell1 (r_cells[line_cell(r_idx[2:0], 2'd1)]),
      .i_cell2 (r_cells[line_cell(r_idx[2:0], 2'd2)]),
      .i_mark  (w_mark),
      .o_hit   (w_hit),
      .o_slot  (w_slot)
   );

   // Next-state, search index and chosen cell for the current search step.
   always_comb begin
      w_next_state = r_state;
      w_next_idx   = r_idx;
      w_choice     = 4'd0;
      if (r_state == S_BLOCK) begin
         w_mark = PLAYER;
      end else begin
         w_mark = COMP;
      end
      case (r_state)
         S_IDLE: begin
            if (move_req) begin
               w_next_idx = 4'd0;
               if (who != 2'b00) begin
                  w_next_state = S_NONE;
               end else begin
                  w_next_state = S_WIN;
               end
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_WIN, S_BLOCK: begin
            if (w_hit) begin
               w_choice     = line_cell(r_idx[2:0], w_slot);
               w_next_state = S_ISSUE;
            end else if (r_idx == 4'd7) begin
               w_next_idx = 4'd0;
               if (r_state == S_WIN && BLOCK_EN) begin
                  w_next_state = S_BLOCK;
               end else begin
                  w_next_state = S_STATIC;
               end
            end else begin
               w_next_idx = r_idx + 4'd1;
            end
         end
         S_STATIC: begin
            // Index 9 is a one-cycle "list exhausted" step before NONE.
            if (r_idx >= 4'd9) begin
               w_next_state = S_NONE;
            end else if (r_cells[w_pref] == EMPTY) begin
               w_choice     = w_pref;
               w_next_state = S_ISSUE;
            end else begin
               w_next_idx = r_idx + 4'd1;
            end
         end
         S_ISSUE: w_next_state = S_IDLE;
         S_NONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // State, snapshot and registered outputs; reset abandons any search.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_idx     <= 4'd0;
         r_pos     <= POS_W'(POS_NONE);
         r_pc      <= 1'b0;
         r_busy    <= 1'b0;
         r_no_move <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            r_cells[i] <= EMPTY;
         end
      end else begin
         r_state   <= w_next_state;
         r_idx     <= w_next_idx;
         r_pc      <= (w_next_state == S_ISSUE);
         r_no_move <= (w_next_state == S_NONE);
         r_busy    <= (w_next_state != S_IDLE);
         if (w_next_state == S_ISSUE) begin
            r_pos <= POS_W'(w_choice);
         end
         if (r_state == S_IDLE && move_req) begin
            for (int i = 0; i < 9; i++) begin
               r_cells[i] <= w_board[i];
            end
         end
      end
   end

   assign computer_position = r_pos;
   assign pc                = r_pc;
   assign busy              = r_busy;
   assign no_move           = r_no_move;

endmodule

// File: tb/tb_computer_move_generator.sv
// Directed bench for computer_move_generator: expected events (kind,
// latency, cell code) are queued when a request is issued and compared
// when the design strobes pc or no_move.
module tb_computer_move_generator;

   logic       clock = 1'b0;
   logic       reset;
   logic       move_req;
   logic [1:0] board [9];
   logic [1:0] who;
   logic [3:0] pos_h, pos_e;
   logic       pc_h, pc_e, busy_h, busy_e, nm_h, nm_e;
   logic       use_easy;

   typedef struct {
      logic       is_pc;
      int         lat;
      logic [3:0] pos;
   } exp_t;

   exp_t       exp_q [$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         t_req;
   logic [3:0] last_pos;

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   computer_move_generator #(.BLOCK_EN(1'b1), .POS_W(4)) dut (
      .clock(clock), .reset(reset), .move_req(move_req),
      .pos1(board[0]), .pos2(board[1]), .pos3(board[2]),
      .pos4(board[3]), .pos5(board[4]), .pos6(board[5]),
      .pos7(board[6]), .pos8(board[7]), .pos9(board[8]),
      .who(who), .computer_position(pos_h), .pc(pc_h),
      .busy(busy_h), .no_move(nm_h)
   );

   computer_move_generator #(.BLOCK_EN(1'b0), .POS_W(4)) dut_easy (
      .clock(clock), .reset(reset), .move_req(move_req),
      .pos1(board[0]), .pos2(board[1]), .pos3(board[2]),
      .pos4(board[3]), .pos5(board[4]), .pos6(board[5]),
      .pos7(board[6]), .pos8(board[7]), .pos9(board[8]),
      .who(who), .computer_position(pos_e), .pc(pc_e),
      .busy(busy_e), .no_move(nm_e)
   );

   wire [3:0] w_pos  = use_easy ? pos_e  : pos_h;
   wire       w_pc   = use_easy ? pc_e   : pc_h;
   wire       w_busy = use_easy ? busy_e : busy_h;
   wire       w_nm   = use_easy ? nm_e   : nm_h;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input logic is_pc, input int lat, input logic [3:0] pos);
      exp_t e;
      e.is_pc = is_pc;
      e.lat   = lat;
      e.pos   = pos;
      exp_q.push_back(e);
   endtask

   task automatic clear_board();
      for (int i = 0; i < 9; i++) board[i] = 2'b00;
   endtask

   // Pulse move_req so it is sampled at one rising edge; t_req marks it.
   task automatic do_req(input logic [1:0] who_v);
      @(negedge clock);
      who      = who_v;
      move_req = 1'b1;
      @(posedge clock);
      #1 t_req = cyc;
      @(negedge clock);
      move_req = 1'b0;
   endtask

   // Wait (bounded) for pc or no_move on the selected instance and score it.
   task automatic wait_event(input string tag, input int budget);
      int   busy_bad = 0;
      bit   seen = 1'b0;
      exp_t e;
      for (int i = 0; i < budget && !seen; i++) begin
         if (w_pc || w_nm) begin
            seen = 1'b1;
         end else begin
            if (!w_busy) busy_bad++;
            @(negedge clock);
         end
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s.timeout observed=none expected=event", tag);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s.unexpected observed=event expected=none", tag);
      end else begin
         e = exp_q.pop_front();
         check({tag, ".pc"},       32'(w_pc), 32'(e.is_pc));
         check({tag, ".no_move"},  32'(w_nm), 32'(!e.is_pc));
         check({tag, ".latency"},  32'(cyc - t_req + 1), 32'(e.lat));
         check({tag, ".pos"},      32'(w_pos), 32'(e.pos));
         check({tag, ".busy_evt"}, 32'(w_busy), 32'd1);
         check({tag, ".busy_gap"}, 32'(busy_bad), 32'd0);
         @(negedge clock);
         check({tag, ".strobe_1cyc"}, 32'(w_pc | w_nm), 32'd0);
         check({tag, ".busy_drop"},   32'(w_busy), 32'd0);
         check({tag, ".pos_hold"},    32'(w_pos), 32'(e.pos));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      reset    = 1'b1;
      move_req = 1'b0;
      who      = 2'b00;
      use_easy = 1'b0;
      clear_board();
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("rst.pos",     32'(pos_h),  32'd15);
      check("rst.pc",      32'(pc_h),   32'd0);
      check("rst.busy",    32'(busy_h), 32'd0);
      check("rst.no_move", 32'(nm_h),   32'd0);
      last_pos = 4'd15;

      // Empty board: static centre.
      clear_board();
      push_exp(1'b1, 18, 4'd4);
      do_req(2'b00);
      wait_event("empty", 40);
      last_pos = 4'd4;
      repeat (12) @(negedge clock);

      // Reset at T+5 abandons the search.
      clear_board();
      do_req(2'b00);
      repeat (4) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (pc_h || pc_e) cnt++;
         @(negedge clock);
      end
      check("midrst.pc_count", 32'(cnt),    32'd0);
      check("midrst.pos",      32'(pos_h),  32'd15);
      check("midrst.busy",     32'(busy_h), 32'd0);
      last_pos = 4'd15;

      // Win on line 0 beats block on line 1.
      clear_board();
      board[0] = 2'b10; board[1] = 2'b10; board[3] = 2'b01; board[4] = 2'b01;
      push_exp(1'b1, 2, 4'd2);
      do_req(2'b00);
      wait_event("win0", 40);
      last_pos = 4'd2;
      repeat (20) @(negedge clock);

      // Block on line 1.
      clear_board();
      board[3] = 2'b01; board[4] = 2'b01; board[0] = 2'b10;
      push_exp(1'b1, 11, 4'd5);
      do_req(2'b00);
      wait_event("block1", 40);
      last_pos = 4'd5;
      repeat (12) @(negedge clock);

      // Same board, easy opponent: static entry 2 (cell 3).
      use_easy = 1'b1;
      push_exp(1'b1, 12, 4'd2);
      do_req(2'b00);
      wait_event("easy", 40);
      use_easy = 1'b0;
      repeat (12) @(negedge clock);

      // Win on the last line (3,5,7).
      clear_board();
      board[2] = 2'b10; board[4] = 2'b10;
      push_exp(1'b1, 9, 4'd6);
      do_req(2'b00);
      wait_event("win7", 40);
      last_pos = 4'd6;
      repeat (12) @(negedge clock);

      // Block on the last line (3,5,7).
      clear_board();
      board[2] = 2'b01; board[4] = 2'b01;
      push_exp(1'b1, 17, 4'd6);
      do_req(2'b00);
      wait_event("block7", 40);
      last_pos = 4'd6;
      repeat (12) @(negedge clock);

      // Code 11 counts as occupied: centre skipped, cell 1 chosen.
      clear_board();
      board[4] = 2'b11;
      push_exp(1'b1, 19, 4'd0);
      do_req(2'b00);
      wait_event("occ11", 40);
      last_pos = 4'd0;
      repeat (12) @(negedge clock);

      // Full board, no winner.
      board[0] = 2'b10; board[1] = 2'b01; board[2] = 2'b10;
      board[3] = 2'b10; board[4] = 2'b01; board[5] = 2'b01;
      board[6] = 2'b01; board[7] = 2'b10; board[8] = 2'b10;
      push_exp(1'b0, 27, last_pos);
      do_req(2'b00);
      wait_event("full", 40);
      repeat (12) @(negedge clock);

      // Game already won by the player.
      clear_board();
      push_exp(1'b0, 1, last_pos);
      do_req(2'b01);
      wait_event("won", 10);
      who = 2'b00;
      repeat (12) @(negedge clock);

      // Second request while busy is ignored.
      clear_board();
      push_exp(1'b1, 18, 4'd4);
      do_req(2'b00);
      repeat (2) @(negedge clock);
      move_req = 1'b1;
      @(negedge clock);
      move_req = 1'b0;
      wait_event("dblreq", 40);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (pc_h || busy_h) cnt++;
         @(negedge clock);
      end
      check("dblreq.extra", 32'(cnt), 32'd0);
      check("queue_empty",  32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
